// File: rtl/candidate_reader.sv
// rtl/candidate_reader.sv - fetches 128-bit candidates from the generator and streams them as 16 bytes (optional CANDIDATE_COUNT_EN)
module candidate_reader #(
    parameter int GEN_LATENCY = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         enable,
    output logic         gen_req,
    input  logic [127:0] chars_in,
    input  logic         exhausted_in,
    output logic [7:0]   byte_out,
    output logic         byte_valid,
    input  logic         byte_ready,
    output logic         frame_last,
    output logic         busy,
    output logic         done
`ifdef CANDIDATE_COUNT_EN
    ,
    output logic [31:0]  cand_count
`endif
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_REQ  = 3'd1;
    localparam logic [2:0] S_WAIT = 3'd2;
    localparam logic [2:0] S_LOAD = 3'd3;
    localparam logic [2:0] S_SEND = 3'd4;
    localparam logic [2:0] S_DONE = 3'd5;

    // WAIT spans GEN_LATENCY cycles, so the counter starts one below it
    localparam logic [3:0] WAIT_INIT = 4'(GEN_LATENCY - 1);

    logic [2:0]   r_state;
    logic [3:0]   r_wait_cnt;
    logic [127:0] r_shreg;
    logic [3:0]   r_idx;
    logic         r_last_cand;

    logic         w_hs;
    logic         w_frame_end;

    assign w_hs        = (r_state == S_SEND) && byte_ready;
    assign w_frame_end = w_hs && (r_idx == 4'd15);

    // Fetch / stream sequencer; frames always run to completion once loaded
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_wait_cnt  <= 4'd0;
            r_shreg     <= 128'd0;
            r_idx       <= 4'd0;
            r_last_cand <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (enable) begin
                        r_state <= S_REQ;
                    end
                end
                S_REQ: begin
                    r_wait_cnt <= WAIT_INIT;
                    r_state    <= S_WAIT;
                end
                S_WAIT: begin
                    if (r_wait_cnt == 4'd0) begin
                        r_state <= S_LOAD;
                    end else begin
                        r_wait_cnt <= r_wait_cnt - 4'd1;
                    end
                end
                S_LOAD: begin
                    r_shreg     <= chars_in;
                    r_last_cand <= exhausted_in;
                    r_idx       <= 4'd0;
                    r_state     <= S_SEND;
                end
                S_SEND: begin
                    if (byte_ready) begin
                        r_shreg <= {r_shreg[119:0], 8'h00};
                        if (r_idx == 4'd15) begin
                            r_idx <= 4'd0;
                            if (r_last_cand) begin
                                r_state <= S_DONE;
                            end else if (enable) begin
                                r_state <= S_REQ;
                            end else begin
                                r_state <= S_IDLE;
                            end
                        end else begin
                            r_idx <= r_idx + 4'd1;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_DONE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign gen_req    = (r_state == S_REQ);
    assign byte_valid = (r_state == S_SEND);
    assign byte_out   = r_shreg[127:120];
    assign frame_last = (r_state == S_SEND) && (r_idx == 4'd15);
    assign busy       = (r_state != S_IDLE) && (r_state != S_DONE);
    assign done       = (r_state == S_DONE);

`ifdef CANDIDATE_COUNT_EN
    logic [31:0] r_cand_count;

    // Count completed frames, saturating rather than wrapping
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cand_count <= 32'd0;
        end else if (w_frame_end && (r_cand_count != 32'hFFFF_FFFF)) begin
            r_cand_count <= r_cand_count + 32'd1;
        end
    end

    assign cand_count = r_cand_count;
`endif

endmodule

// File: tb/tb_candidate_reader.sv
// tb/tb_candidate_reader.sv - self-checking bench for candidate_reader
module tb_candidate_reader;

    localparam int L = 2;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         enable = 1'b0;
    logic         gen_req;
    logic [127:0] chars_in = 128'd0;
    logic         exhausted_in = 1'b0;
    logic [7:0]   byte_out;
    logic         byte_valid;
    logic         byte_ready = 1'b1;
    logic         frame_last;
    logic         busy;
    logic         done;
`ifdef CANDIDATE_COUNT_EN
    logic [31:0]  cand_count;
`endif

    candidate_reader #(.GEN_LATENCY(L)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .enable(enable),
        .gen_req(gen_req),
        .chars_in(chars_in),
        .exhausted_in(exhausted_in),
        .byte_out(byte_out),
        .byte_valid(byte_valid),
        .byte_ready(byte_ready),
        .frame_last(frame_last),
        .busy(busy),
        .done(done)
`ifdef CANDIDATE_COUNT_EN
        ,
        .cand_count(cand_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [127:0] data;
        logic         exh;
    } cand_t;

    typedef struct {
        logic [127:0] data;
        int           mode;
        int           exp_cycles;
        logic [7:0]   exp_first;
        logic [7:0]   exp_last;
    } vec_t;

    int checks = 0;
    int failures = 0;

    // reference model state
    cand_t      cand_q[$];
    logic [7:0] exp_q[$];
    int         cyc = 0;
    int         req_cyc = 0;
    int         gen_cnt = 0;
    int         frames_done = 0;
    int         hs_in_frame = 0;
    int         send_k = 0;
    int         frame_cycles = 0;
    int         ready_mode = 0;
    logic       pending = 1'b0;
    logic       cur_exh = 1'b0;
    logic       exp_done = 1'b0;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_byte = 8'h00;
    logic       frame_end_pending = 1'b0;
    logic [7:0] first_byte = 8'h00;
    logic [7:0] last_byte = 8'h00;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        logic  en_e;
        logic  rst_e;
        logic  r;
        int    k;
        cand_t c;
        logic [7:0] eb;
        en_e  = enable;
        rst_e = rst_n;
        @(posedge clk);
        #1;
        cyc++;
        if (!rst_e) begin
            byte_ready = 1'b1;
        end else begin
            if (frame_end_pending) begin
                frame_end_pending = 1'b0;
                if (cur_exh) begin
                    check("done_after_final", done, 1);
                    check("busy_after_final", busy, 0);
                    check("no_req_after_final", gen_req, 0);
                    exp_done = 1'b1;
                end else if (en_e) begin
                    check("b2b_gen_req", gen_req, 1);
                end else begin
                    check("idle_no_req", gen_req, 0);
                    check("idle_busy", busy, 0);
                end
            end
            check("done_level", done, exp_done);
            if (gen_req) begin
                gen_cnt++;
                check("gen_req_enable", en_e, 1);
                check("gen_req_not_pending", pending, 0);
                check("gen_req_after_done", exp_done, 0);
                pending = 1'b1;
                req_cyc = cyc;
                if (cand_q.size() != 0) begin
                    c = cand_q.pop_front();
                end else begin
                    c.data = {$urandom(), $urandom(), $urandom(), $urandom()};
                    c.exh  = 1'b0;
                end
                chars_in     = c.data;
                exhausted_in = c.exh;
                cur_exh      = c.exh;
                for (int i = 0; i < 16; i++) begin
                    exp_q.push_back(c.data[127 - 8*i -: 8]);
                end
            end
            if (prev_stall) begin
                check("stall_valid", byte_valid, 1);
                check("stall_hold", byte_out, prev_byte);
            end
            if (byte_valid && send_k == 0) begin
                check("first_valid_pending", pending, 1);
                check("first_byte_latency", cyc - req_cyc, L + 2);
                pending = 1'b0;
                chars_in = {$urandom(), $urandom(), $urandom(), $urandom()};
                exhausted_in = 1'($urandom_range(0, 1));
            end
            k = send_k;
            case (ready_mode)
                0: r = 1'b1;
                1: r = ((k % 4) == 0) || ((k % 4) == 3);
                2: r = ((k % 4) == 0);
                3: r = !((hs_in_frame == 15) && (k < 40));
                default: r = ($urandom_range(0, 3) != 0);
            endcase
            byte_ready = r;
            if (byte_valid) send_k++;
            prev_stall = byte_valid && !r;
            prev_byte  = byte_out;
            if (byte_valid && r) begin
                check("scoreboard_has_byte", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    eb = exp_q.pop_front();
                    check("byte", byte_out, eb);
                end
                check("frame_last", frame_last, hs_in_frame == 15);
                if (hs_in_frame == 0) first_byte = byte_out;
                hs_in_frame++;
                if (hs_in_frame == 16) begin
                    frames_done++;
                    last_byte = byte_out;
                    frame_cycles = send_k;
                    send_k = 0;
                    hs_in_frame = 0;
                    frame_end_pending = 1'b1;
                end
            end
        end
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        step();
        check("rst_byte_valid", byte_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_gen_req", gen_req, 0);
        check("rst_done", done, 0);
        check("rst_byte_out", byte_out, 0);
        check("rst_frame_last", frame_last, 0);
        exp_q.delete();
        pending = 1'b0;
        hs_in_frame = 0;
        send_k = 0;
        exp_done = 1'b0;
        prev_stall = 1'b0;
        frame_end_pending = 1'b0;
        cur_exh = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic wait_frames(input int target, input int budget, input string name);
        int n;
        n = 0;
        while (frames_done < target && n < budget) begin
            step();
            n++;
        end
        check(name, frames_done >= target, 1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t  tbl[3];
        cand_t c;
        int    f0;
        int    g0;
        int    n;

        tbl[0] = '{128'h41424344_45464748_494A4B4C_4D4E4F50, 0, 16, 8'h41, 8'h50};
        tbl[1] = '{128'h00112233_44556677_8899AABB_CCDDEEFF, 1, 32, 8'h00, 8'hFF};
        tbl[2] = '{128'hFFEEDDCC_BBAA9988_77665544_33221100, 2, 61, 8'hFF, 8'h00};

        apply_reset();

        // table-driven frames: full rate, 1,0,0,1 backpressure, 1,0,0,0 backpressure
        for (int i = 0; i < 3; i++) begin
            c.data = tbl[i].data;
            c.exh  = 1'b0;
            cand_q.push_back(c);
            ready_mode = tbl[i].mode;
            enable = 1'b1;
            wait_frames(frames_done + 1, 300, "table_frame_done");
            check("table_first_byte", first_byte, tbl[i].exp_first);
            check("table_last_byte", last_byte, tbl[i].exp_last);
            check("table_send_cycles", frame_cycles, tbl[i].exp_cycles);
        end

        // enable dropped after byte 5: frame completes, then idles
        ready_mode = 0;
        n = 0;
        while (hs_in_frame != 6 && n < 200) begin
            step();
            n++;
        end
        check("reach_byte6", hs_in_frame, 6);
        enable = 1'b0;
        f0 = frames_done;
        g0 = gen_cnt;
        wait_frames(f0 + 1, 100, "drop_frame_done");
        for (int i = 0; i < 30; i++) step();
        check("no_req_while_disabled", gen_cnt, g0);
        check("idle_busy_low", busy, 0);
        enable = 1'b1;
        n = 0;
        while (gen_cnt == g0 && n < 5) begin
            step();
            n++;
        end
        check("req_on_reenable", gen_cnt, g0 + 1);

        // randomized backpressure over random candidates
        ready_mode = 4;
        wait_frames(frames_done + 20, 3000, "random_frames_done");

        // reset mid-frame at byte 8
        ready_mode = 0;
        n = 0;
        while (hs_in_frame != 8 && n < 200) begin
            step();
            n++;
        end
        check("reach_byte8", hs_in_frame, 8);
        apply_reset();
        c.data = 128'hA0A1A2A3_A4A5A6A7_A8A9AAAB_ACADAEAF;
        c.exh  = 1'b0;
        cand_q.push_back(c);
        g0 = gen_cnt;
        n = 0;
        while (gen_cnt == g0 && n < 5) begin
            step();
            n++;
        end
        check("req_after_reset", gen_cnt, g0 + 1);
        wait_frames(frames_done + 1, 100, "post_reset_frame");
        check("post_reset_first", first_byte, 8'hA0);
        check("post_reset_last", last_byte, 8'hAF);

`ifdef CANDIDATE_COUNT_EN
        enable = 1'b0;
        apply_reset();
        check("count_reset", cand_count, 0);
        enable = 1'b1;
        ready_mode = 0;
        wait_frames(frames_done + 2, 200, "count_two_frames");
        ready_mode = 3;
        n = 0;
        while (!(byte_valid && hs_in_frame == 15) && n < 100) begin
            step();
            n++;
        end
        check("count_reach_last", frame_last, 1);
        for (int i = 0; i < 5; i++) begin
            step();
            check("count_hold_in_stall", cand_count, 2);
        end
        wait_frames(frames_done + 1, 100, "count_third_frame");
        enable = 1'b0;
        step();
        check("count_three", cand_count, 3);
`endif

        // exhaustion flagged at the second LOAD
        enable = 1'b0;
        ready_mode = 0;
        apply_reset();
        c.data = 128'h10111213_14151617_18191A1B_1C1D1E1F;
        c.exh  = 1'b0;
        cand_q.push_back(c);
        c.data = 128'h20212223_24252627_28292A2B_2C2D2E2F;
        c.exh  = 1'b1;
        cand_q.push_back(c);
        enable = 1'b1;
        wait_frames(frames_done + 2, 200, "exhaust_frames");
        check("exhaust_last_byte", last_byte, 8'h2F);
        step();
        g0 = gen_cnt;
        for (int i = 0; i < 100; i++) step();
        check("no_third_req", gen_cnt, g0);
        check("done_sticky", done, 1);
        check("busy_in_done", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/candidate_reader.md
# candidate_reader

Consumer-side counterpart to the character generator. Requests one candidate at a time over the generator's `start_gen`/`characters_bitstream`/`exhausted` interface and latches the 128-bit candidate. It then streams the candidate as 16 bytes over a valid/ready byte interface to the downstream hashing or UART stage. It stops cleanly when the generator reports exhaustion.

## Interface
Parameters:
- `GEN_LATENCY`, 2: cycles from `gen_req` pulse to valid `chars_in`/`exhausted_in`; legal range 1–15.

Ports:
- `clk` in 1: single clock, all logic on rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `enable` in 1: level; high runs the fetch/stream loop.
- `gen_req` out 1: one-cycle pulse, drives generator `start_gen`.
- `chars_in` in 128: candidate from generator `characters_bitstream`.
- `exhausted_in` in 1: generator `exhausted`.
- `byte_out` out 8: current candidate byte.
- `byte_valid` out 1: `byte_out` valid.
- `byte_ready` in 1: downstream accepts when `byte_valid && byte_ready`.
- `frame_last` out 1: high with byte index 15.
- `busy` out 1: high in any state except IDLE/DONE.
- `done` out 1: high in DONE.

## Operation
- States: IDLE, REQ, WAIT, LOAD, SEND, DONE.
- IDLE: if `enable`, go to REQ; otherwise stay.
- REQ: assert `gen_req` for exactly this cycle; load the wait counter with `GEN_LATENCY-1`; go to WAIT.
- WAIT: decrement counter; at 0, go to LOAD.
- LOAD: `shreg <= chars_in`; `last_cand <= exhausted_in`; byte index <= 0; go to SEND.
- SEND: `byte_out = shreg[127:120]`, i.e. most-significant byte first. `byte_valid=1`.
- On a SEND handshake:
  - Shift `shreg` left 8 and increment the index.
  - If the index was 15 and `last_cand`, go to DONE.
  - Else if the index was 15 and `enable`, go to REQ.
  - Else if the index was 15, go to IDLE.
  - Else stay in SEND.
- Without a handshake, `byte_out`, `byte_valid` and the index hold. Stall length is unbounded.
- `enable` deasserted mid-frame: the current frame completes all 16 bytes, then the block goes to IDLE. Frames are never truncated.
- Exhaustion: the candidate loaded while `exhausted_in=1` is the final candidate. It is streamed in full, then the block enters DONE. No further `gen_req` is issued.
- DONE: sticky until `rst_n` low. `enable` is ignored.
- `exhausted_in` is sampled only in LOAD. It is ignored in all other states.
- Index is 4 bits and never wraps inside SEND; the transition at 15 is explicit.

## Timing
- Reset values (next edge with `rst_n=0`):
  - State IDLE.
  - `gen_req=0`, `byte_valid=0`, `byte_out=8'h00`, `frame_last=0`, `busy=0`, `done=0`.
  - `shreg=0`, index=0, `last_cand=0`.
- Reset mid-frame aborts the frame immediately. No partial-frame recovery.
- All outputs are registered or decoded directly from registered state, with no combinational path from `byte_ready`.
- Per-candidate overhead: 1 (REQ) + `GEN_LATENCY` (WAIT) + 1 (LOAD) cycles before the first byte.
- With `byte_ready` held high, the 16 bytes take 16 consecutive cycles.
- Full-rate period is `GEN_LATENCY+18` cycles per candidate.
- `gen_req` is never asserted twice without an intervening LOAD.

## Configuration
- `CANDIDATE_COUNT_EN` defined:
  - Adds output `cand_count` (32 bits), reset 0.
  - Increments on the handshake of the byte where `frame_last=1`.
  - Saturates at 32'hFFFF_FFFF.
- `CANDIDATE_COUNT_EN` undefined: the port and counter are absent. All other behaviour is identical.

## Test plan
- Basic frame: reset, `GEN_LATENCY=2`, `chars_in=128'h41424344_45464748_494A4B4C_4D4E4F50`, `enable=1`, `byte_ready=1`.
  - Expect one `gen_req` pulse.
  - Then 16 bytes 0x41..0x50 on consecutive cycles, `frame_last` on 0x50.
  - Next `gen_req` on the cycle after the 0x50 handshake.
- Backpressure: `byte_ready` toggles 1,0,0,1 repeating.
  - `byte_out` holds through the stalls.
  - Exactly 16 handshakes occur, in order, with no duplicates.
- Exhaustion: `exhausted_in=1` at the second LOAD.
  - Second frame streams fully, then `done=1`, `busy=0`.
  - No third `gen_req`, even with `enable` held for 100 cycles.
- Enable drop: `enable=0` after byte 5 of a frame.
  - Bytes 6–15 still complete, then IDLE.
  - No `gen_req` until `enable` returns high.
- Reset mid-frame: `rst_n=0` for 1 cycle at byte 8.
  - Next cycle: `byte_valid=0`, `busy=0`, state IDLE.
  - With `enable=1` after release, a fresh `gen_req` is issued and the new frame starts at byte 0.
- Counter (`CANDIDATE_COUNT_EN`): stream 3 frames.
  - `cand_count=3`.
  - `cand_count` is unchanged during a stall on byte 15 and increments only on that byte's handshake.
